// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve unit and its prediction queue.
package branch_pkg;

  // One in-flight prediction as captured from the fetch stage.
  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
    logic        compressed;
  } pred_entry_t;

  typedef enum logic [0:0] {
    StRun      = 1'b0,
    StRedirect = 1'b1
  } bru_state_e;

  localparam logic [31:0] PcIncCompressed = 32'd2;
  localparam logic [31:0] PcIncFull       = 32'd4;

  // Address of the next sequential instruction; wraps modulo 2^32.
  function automatic logic [31:0] fallthrough_pc(input pred_entry_t e);
    return e.pc + (e.compressed ? PcIncCompressed : PcIncFull);
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of outstanding predictions with a synchronous flush.
module pred_fifo
  import branch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  pred_entry_t data_i,
  input  logic        pop_i,
  output pred_entry_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  pred_entry_t   mem_q [Depth];
  logic          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  // Pointer next-state; flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks in-flight branch predictions, checks them against execute outcomes and
// requests a one-cycle fetch redirect on a mispredict.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pred_valid_i,
  output logic        pred_ready_o,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_pc_i,
  input  logic [31:0] pred_target_i,
  input  logic        pred_compressed_i,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  input  logic        res_taken_i,
  input  logic [31:0] res_target_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [15:0] branch_cnt_o,
  output logic [15:0] mispredict_cnt_o
);

  bru_state_e  state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] mispredict_cnt_q, mispredict_cnt_d;

  pred_entry_t push_entry, head;
  logic        fifo_full, fifo_empty;
  logic        push, pop, mispredict;
  logic [31:0] correct_pc;

  assign push_entry = '{
    taken:      pred_taken_i,
    pc:         pred_pc_i,
    target:     pred_target_i,
    compressed: pred_compressed_i
  };

  assign pred_ready_o = (state_q == StRun) & ~fifo_full;
  assign res_ready_o  = (state_q == StRun) & ~fifo_empty;
  assign push         = pred_valid_i & pred_ready_o;
  assign pop          = res_valid_i & res_ready_o;

  // A target mismatch only matters when both sides agree the branch is taken.
  assign mispredict = pop & ((res_taken_i != head.taken) |
                             (res_taken_i & head.taken & (res_target_i != head.target)));
  assign correct_pc = res_taken_i ? res_target_i : fallthrough_pc(head);

  pred_fifo #(
    .Depth (DEPTH)
  ) u_pred_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (mispredict),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM next-state and the redirect PC, which is zero outside the redirect cycle.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = '0;
    unique case (state_q)
      StRun: begin
        if (mispredict) begin
          state_d       = StRedirect;
          redirect_pc_d = correct_pc;
        end
      end
      StRedirect: state_d = StRun;
      default:    state_d = StRun;
    endcase
  end

  // Saturating resolution and mispredict counters.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (pop && (branch_cnt_q != 16'hFFFF)) begin
      branch_cnt_d = branch_cnt_q + 16'd1;
    end
    if (mispredict && (mispredict_cnt_q != 16'hFFFF)) begin
      mispredict_cnt_d = mispredict_cnt_q + 16'd1;
    end
  end

  // State, redirect PC and counters with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q          <= StRun;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign redirect_o       = (state_q == StRedirect);
  assign redirect_pc_o    = redirect_pc_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule
